xor_frame_checksum: RTL
=======================

Name: xor_frame_checksum

Overview:
Parametrised, clocked XOR checksum engine. Folds a stream of WIDTH-bit words into one WIDTH-bit XOR sum per frame.
- Input and output use valid/ready handshakes; frames are delimited by IN_LAST.
- Frame length is bounded by MAX_WORDS, with overflow reported on OUT_ERR.
- Sits between a word-stream producer and the checker that consumes per-frame integrity sums.
- Sequential successor to the team's fixed 8-bit combinational XOR gate block.

Parameters:
WIDTH, 8, data/sum width in bits (>=1)
MAX_WORDS, 16, maximum words folded into one sum (>=1)
CNT_W, 5, width of word counter; must satisfy 2**CNT_W > MAX_WORDS

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  reset, synchronous, active-low
IN_VALID  input  1  producer has a word on IN_DATA
IN_READY  output  1  block accepts a word this cycle
IN_DATA  input  WIDTH  data word
IN_LAST  input  1  word is final word of frame (qualified by IN_VALID)
OUT_VALID  output  1  checksum result available
OUT_READY  input  1  consumer takes result this cycle
OUT_SUM  output  WIDTH  XOR checksum of frame
OUT_COUNT  output  CNT_W  number of words folded into OUT_SUM
OUT_ERR  output  1  frame exceeded MAX_WORDS
BUSY  output  1  high in any state other than IDLE

Behaviour:
- One clock domain: CLK. Reset is synchronous and active-low: RST_N sampled low at a rising CLK edge forces reset.
- Reset values: state=IDLE, OUT_SUM=0, OUT_COUNT=0, OUT_ERR=0, OUT_VALID=0, BUSY=0. IN_READY=1 in IDLE.
- Reset applies mid-operation from any state; any partial frame is discarded with no output.
- Word accepted iff IN_VALID && IN_READY at a rising edge. Result taken iff OUT_VALID && OUT_READY.
- IN_READY = 1 in IDLE, ACCUM, DRAIN; 0 in DONE. OUT_VALID = 1 only in DONE. All outputs registered or decoded from state.
- IDLE: on accept, load acc=IN_DATA and cnt=1.
  - If IN_LAST -> DONE.
  - Else if MAX_WORDS==1 -> DRAIN, err=1.
  - Else -> ACCUM.
- ACCUM: on accept, acc=acc^IN_DATA and cnt=cnt+1.
  - If IN_LAST -> DONE.
  - Else if new cnt==MAX_WORDS -> DRAIN, err=1.
  - No accept: hold.
- DRAIN: accepted words are discarded; acc and cnt are frozen. On accepted IN_LAST -> DONE.
- DONE: hold OUT_SUM/OUT_COUNT/OUT_ERR stable. On OUT_READY -> IDLE, clearing err.
  - OUT_SUM/OUT_COUNT keep their last values until the next frame's first word loads.
- Latency: OUT_VALID asserts the cycle after the LAST word is accepted. Minimum frame-to-frame period is 2 cycles (1-word frame + immediate OUT_READY).
- Boundaries:
  - A frame of exactly MAX_WORDS words with LAST on word MAX_WORDS gives ERR=0.
  - The (MAX_WORDS+1)-th word onward is dropped and ERR=1.
  - cnt never exceeds MAX_WORDS.
  - IN_DATA/IN_LAST are ignored when IN_VALID=0.
  - OUT_READY is ignored when OUT_VALID=0.
- Arithmetic: pure bitwise XOR at WIDTH bits; no carries; cnt is unsigned CNT_W.

Optional Feature:
Macro CKSUM_ROTATE_EN.
- Defined: every fold after the first computes acc = rotl1(acc) ^ IN_DATA (rotate left by one bit within WIDTH, MSB to LSB). This makes the sum sensitive to word order. The first-word load is unchanged.
- Undefined: plain XOR fold as above; no rotate logic is synthesised.
- Ports and handshake are identical either way.

Test Plan:
All scenarios use WIDTH=8, MAX_WORDS=4, OUT_READY=1 unless stated.
1. Single word A5 with LAST -> next cycle OUT_VALID=1, OUT_SUM=A5, OUT_COUNT=1, OUT_ERR=0; IDLE the cycle after.
2. Frame FF,01,00,FF, LAST on 4th -> OUT_SUM=01, OUT_COUNT=4, OUT_ERR=0. Then frame 59,BE,AA,72 -> OUT_SUM=3F.
3. Overflow: 01,02,04,08,10,20 with LAST on 6th -> words 5-6 dropped, IN_READY=1 throughout; OUT_SUM=0F, OUT_COUNT=4, OUT_ERR=1, OUT_VALID the cycle after word 6.
4. Backpressure: after 1-word frame 3C, hold OUT_READY=0 for 3 cycles with IN_VALID=1 -> OUT_VALID=1, OUT_SUM=3C stable, IN_READY=0, no word consumed. Release -> IDLE, then accepts the pending word.
5. RST_N=0 for one edge after 2 words (11,22) of a frame -> BUSY=0, OUT_VALID=0, OUT_SUM=0. Then new frame 3C with LAST -> OUT_SUM=3C, OUT_COUNT=1.
6. With CKSUM_ROTATE_EN: frame 81,01 -> OUT_SUM=02. Without the macro the same frame -> OUT_SUM=80.

Source files
------------

// File: rtl/xor_frame_checksum.sv
// Frame XOR checksum engine: folds a valid/ready word stream into one sum per IN_LAST-delimited frame.
// Optional macro CKSUM_ROTATE_EN makes each fold after the first rotate the sum left by one bit.
module xor_frame_checksum #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic [CNT_W-1:0] OUT_COUNT,
  output logic             OUT_ERR,
  output logic             BUSY
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_WORDS);
  localparam bit               OneWord = (MAX_WORDS == 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q;
  logic             accept;

`ifdef CKSUM_ROTATE_EN
  logic [WIDTH-1:0] acc_rot;

  if (WIDTH > 1) begin : g_rot
    assign acc_rot = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
  end else begin : g_no_rot
    assign acc_rot = acc_q;
  end

  always_comb fold = acc_rot ^ IN_DATA;
`else
  always_comb fold = acc_q ^ IN_DATA;
`endif

  always_comb begin
    IN_READY  = (state_q != StDone);
    OUT_VALID = (state_q == StDone);
    BUSY      = (state_q != StIdle);
    OUT_SUM   = acc_q;
    OUT_COUNT = cnt_q;
    OUT_ERR   = err_q;
    accept    = IN_VALID && IN_READY;
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q <= IN_DATA;
            cnt_q <= CNT_W'(1);
            if (IN_LAST) begin
              state_q <= StDone;
            end else if (OneWord) begin
              state_q <= StDrain;
              err_q   <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            acc_q <= fold;
            cnt_q <= cnt_inc;
            if (IN_LAST) begin
              state_q <= StDone;
            end else if (cnt_inc == MaxCnt) begin
              state_q <= StDrain;
              err_q   <= 1'b1;
            end
          end
        end
        // Overflowed words are swallowed until the frame's LAST arrives.
        StDrain: begin
          if (accept && IN_LAST) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (OUT_READY) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
